// File: rtl/rtc_timekeeper.sv
// BCD real-time calendar: divides clk to 1 Hz and keeps sec/min/hour/weekday/date/month/year.
// Define RTC_LEAP_YEAR_EN to give February 29 days in years divisible by four.
module rtc_timekeeper #(
    parameter int CLK_HZ = 32768
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_err,
    output logic [7:0] real_sec,
    output logic [7:0] real_min,
    output logic [7:0] real_hour,
    output logic [7:0] real_day,
    output logic [3:0] real_weekday,
    output logic [7:0] real_month,
    output logic [7:0] real_year,
    output logic       sec_tick,
    output logic       min_tick
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc;
    logic          adv;
    logic          write_ok;
    logic          step;
    logic          leap;
    logic [7:0]    dim;
    logic [7:0]    sec_next, min_next, hour_next, day_next, month_next, year_next;
    logic [3:0]    weekday_next;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic field_ok(input logic [2:0] addr, input logic [7:0] v);
        logic ok;
        ok = 1'b0;
        if (bcd_ok(v)) begin
            case (addr)
                3'd0, 3'd1: ok = (v <= 8'h59);
                3'd2:       ok = (v <= 8'h23);
                3'd3:       ok = (v >= 8'h01) && (v <= 8'h07);
                3'd4:       ok = (v >= 8'h01) && (v <= 8'h31);
                3'd5:       ok = (v >= 8'h01) && (v <= 8'h12);
                3'd6:       ok = 1'b1;
                default:    ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic is_leap_yr);
        logic [7:0] d;
        case (month)
            8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
            8'h02:                      d = is_leap_yr ? 8'h29 : 8'h28;
            default:                    d = 8'h31;
        endcase
        return d;
    endfunction

`ifdef RTC_LEAP_YEAR_EN
    // 10*hi contributes 2*hi mod 4, so only hi[0] and the low nibble matter.
    function automatic logic is_leap(input logic [4:0] y);
        logic [4:0] s;
        s = {3'b000, y[4], 1'b0} + {1'b0, y[3:0]};
        return s[1:0] == 2'b00;
    endfunction
`endif

    always_comb begin
`ifdef RTC_LEAP_YEAR_EN
        leap = is_leap(real_year[4:0]);
`else
        leap = 1'b0;
`endif
        dim      = days_in_month(real_month, leap);
        adv      = (presc == PRESC_MAX);
        write_ok = wr_en && field_ok(wr_addr, wr_data);
        step     = adv && !write_ok;
    end

    // An accepted write replaces the whole advance for that cycle.
    always_comb begin
        sec_next     = real_sec;
        min_next     = real_min;
        hour_next    = real_hour;
        day_next     = real_day;
        weekday_next = real_weekday;
        month_next   = real_month;
        year_next    = real_year;
        if (write_ok) begin
            case (wr_addr)
                3'd0:    sec_next     = wr_data;
                3'd1:    min_next     = wr_data;
                3'd2:    hour_next    = wr_data;
                3'd3:    weekday_next = wr_data[3:0];
                3'd4:    day_next     = wr_data;
                3'd5:    month_next   = wr_data;
                3'd6:    year_next    = wr_data;
                default: ;
            endcase
        end else if (adv) begin
            sec_next = (real_sec == 8'h59) ? 8'h00 : bcd_inc(real_sec);
            if (real_sec == 8'h59) begin
                min_next = (real_min == 8'h59) ? 8'h00 : bcd_inc(real_min);
                if (real_min == 8'h59) begin
                    hour_next = (real_hour == 8'h23) ? 8'h00 : bcd_inc(real_hour);
                    if (real_hour == 8'h23) begin
                        weekday_next = (real_weekday == 4'd7) ? 4'd1 : real_weekday + 4'd1;
                        // >= so an over-range date written by firmware still rolls over
                        day_next = (real_day >= dim) ? 8'h01 : bcd_inc(real_day);
                        if (real_day >= dim) begin
                            month_next = (real_month >= 8'h12) ? 8'h01 : bcd_inc(real_month);
                            if (real_month >= 8'h12)
                                year_next = (real_year == 8'h99) ? 8'h00 : bcd_inc(real_year);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            real_sec     <= 8'h00;
            real_min     <= 8'h00;
            real_hour    <= 8'h00;
            real_day     <= 8'h01;
            real_weekday <= 4'd1;
            real_month   <= 8'h01;
            real_year    <= 8'h00;
            sec_tick     <= 1'b0;
            min_tick     <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            presc        <= (adv || (write_ok && wr_addr == 3'd0)) ? '0 : presc + PW'(1);
            real_sec     <= sec_next;
            real_min     <= min_next;
            real_hour    <= hour_next;
            real_day     <= day_next;
            real_weekday <= weekday_next;
            real_month   <= month_next;
            real_year    <= year_next;
            sec_tick     <= step;
            min_tick     <= step && (real_sec == 8'h59);
            wr_err       <= wr_en && !write_ok;
        end
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper (CLK_HZ=4) against a decimal calendar model.
module tb_rtc_timekeeper;

    localparam int CLK_HZ = 4;
`ifdef RTC_LEAP_YEAR_EN
    localparam bit LEAP = 1'b1;
`else
    localparam bit LEAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_err, sec_tick, min_tick;
    logic [7:0] real_sec, real_min, real_hour, real_day, real_month, real_year;
    logic [3:0] real_weekday;
    logic [54:0] dut_bus;

    int checks = 0;
    int errors = 0;

    // Model state in plain decimal
    int ms, mm, mh, md, mwd, mmo, my, mp;
    logic e_st, e_mt, e_we;

    rtc_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .real_sec(real_sec), .real_min(real_min), .real_hour(real_hour),
        .real_day(real_day), .real_weekday(real_weekday), .real_month(real_month),
        .real_year(real_year), .sec_tick(sec_tick), .min_tick(min_tick)
    );

    always #5 clk = ~clk;

    assign dut_bus = {real_sec, real_min, real_hour, real_day, real_weekday,
                      real_month, real_year, sec_tick, min_tick, wr_err};

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int dim(input int mo, input int yr);
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        if (mo == 2) return (LEAP && (yr % 4 == 0)) ? 29 : 28;
        return 31;
    endfunction

    function automatic logic [54:0] model_outputs();
        return {bcd(ms), bcd(mm), bcd(mh), bcd(md), 4'(mwd), bcd(mmo), bcd(my), e_st, e_mt, e_we};
    endfunction

    task automatic model_reset();
        ms = 0; mm = 0; mh = 0; md = 1; mwd = 1; mmo = 1; my = 0; mp = 0;
        e_st = 1'b0; e_mt = 1'b0; e_we = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [2:0] a, input logic [7:0] d);
        int hi, lo, v;
        bit ok, adv;
        hi = int'(d[7:4]);
        lo = int'(d[3:0]);
        v = hi * 10 + lo;
        adv = (mp == CLK_HZ - 1);
        ok = 1'b0;
        if (en && hi <= 9 && lo <= 9) begin
            case (a)
                3'd0, 3'd1: ok = (v <= 59);
                3'd2:       ok = (v <= 23);
                3'd3:       ok = (v >= 1 && v <= 7);
                3'd4:       ok = (v >= 1 && v <= 31);
                3'd5:       ok = (v >= 1 && v <= 12);
                3'd6:       ok = 1'b1;
                default:    ok = 1'b0;
            endcase
        end
        e_st = 1'b0;
        e_mt = 1'b0;
        e_we = en && !ok;
        mp = (adv || (ok && a == 3'd0)) ? 0 : mp + 1;
        if (ok) begin
            case (a)
                3'd0: ms = v;
                3'd1: mm = v;
                3'd2: mh = v;
                3'd3: mwd = v;
                3'd4: md = v;
                3'd5: mmo = v;
                default: my = v;
            endcase
        end else if (adv) begin
            e_st = 1'b1;
            ms = ms + 1;
            if (ms == 60) begin
                ms = 0; e_mt = 1'b1; mm = mm + 1;
                if (mm == 60) begin
                    mm = 0; mh = mh + 1;
                    if (mh == 24) begin
                        mh = 0;
                        mwd = (mwd % 7) + 1;
                        if (md >= dim(mmo, my)) begin
                            md = 1; mmo = mmo + 1;
                            if (mmo == 13) begin
                                mmo = 1; my = (my + 1) % 100;
                            end
                        end else begin
                            md = md + 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic en, input logic [2:0] a, input logic [7:0] d);
        wr_en = en; wr_addr = a; wr_data = d;
        @(posedge clk);
        if (rst_n) model_step(en, a, d);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_bus !== model_outputs()) begin
            errors++; $display("FAIL reset_hold: got %h want %h", dut_bus, model_outputs());
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (dut_bus !== model_outputs()) begin
            errors++; $display("FAIL reset_release: got %h want %h", dut_bus, model_outputs());
        end
        #2;
    endtask

    task automatic test_first_tick();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 3'd0, 8'h00);
            checks++;
            if (dut_bus !== model_outputs()) begin
                errors++; $display("FAIL first_tick cyc %0d: got %h want %h", i, dut_bus, model_outputs());
            end
        end
        checks++;
        if (real_sec !== 8'h01 || sec_tick !== 1'b1) begin
            errors++; $display("FAIL first_tick_value: sec %h tick %b want 01 1", real_sec, sec_tick);
        end
    endtask

    task automatic test_full_rollover();
        logic [2:0] addrs [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
        logic [7:0] vals  [7] = '{8'h59, 8'h23, 8'h07, 8'h31, 8'h12, 8'h99, 8'h59};
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, addrs[i], vals[i]);
            checks++;
            if (dut_bus !== model_outputs()) begin
                errors++; $display("FAIL rollover_write %0d: got %h want %h", i, dut_bus, model_outputs());
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 3'd0, 8'h00);
            checks++;
            if (dut_bus !== model_outputs()) begin
                errors++; $display("FAIL rollover_run %0d: got %h want %h", i, dut_bus, model_outputs());
            end
        end
        checks++;
        if (dut_bus !== {8'h00, 8'h00, 8'h00, 8'h01, 4'd1, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rollover_value: got %h want 00:00:00 01/01/00 wd1 ticks", dut_bus);
        end
    endtask

    task automatic set_time(input logic [7:0] yr, input logic [7:0] mo, input logic [7:0] dt);
        cycle(1'b1, 3'd6, yr);
        cycle(1'b1, 3'd5, mo);
        cycle(1'b1, 3'd4, dt);
        cycle(1'b1, 3'd2, 8'h23);
        cycle(1'b1, 3'd1, 8'h59);
        cycle(1'b1, 3'd0, 8'h59);
    endtask

    task automatic test_feb();
        logic [15:0] want;
        set_time(8'h24, 8'h02, 8'h28);
        repeat (4) cycle(1'b0, 3'd0, 8'h00);
        want = LEAP ? 16'h2902 : 16'h0103;
        checks++;
        if ({real_day, real_month} !== want || real_year !== 8'h24 || dut_bus !== model_outputs()) begin
            errors++; $display("FAIL feb_first: got %h/%h/%h want %h/24", real_day, real_month, real_year, want);
        end
        cycle(1'b1, 3'd2, 8'h23);
        cycle(1'b1, 3'd1, 8'h59);
        cycle(1'b1, 3'd0, 8'h59);
        repeat (4) cycle(1'b0, 3'd0, 8'h00);
        want = LEAP ? 16'h0103 : 16'h0203;
        checks++;
        if ({real_day, real_month} !== want || dut_bus !== model_outputs()) begin
            errors++; $display("FAIL feb_second: got %h/%h want %h", real_day, real_month, want);
        end
    endtask

    task automatic test_bad_writes();
        logic [2:0] addrs [6] = '{3'd0, 3'd7, 3'd2, 3'd3, 3'd5, 3'd4};
        logic [7:0] vals  [6] = '{8'h5A, 8'h00, 8'h24, 8'h00, 8'h13, 8'h00};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, addrs[i], vals[i]);
            checks++;
            if (wr_err !== 1'b1 || dut_bus !== model_outputs()) begin
                errors++; $display("FAIL bad_write %0d: got %h want %h", i, dut_bus, model_outputs());
            end
        end
        cycle(1'b0, 3'd0, 8'h00);
        checks++;
        if (wr_err !== 1'b0) begin
            errors++; $display("FAIL wr_err_pulse: got %b want 0", wr_err);
        end
    endtask

    task automatic test_write_on_adv();
        cycle(1'b1, 3'd0, 8'h10);
        repeat (3) cycle(1'b0, 3'd0, 8'h00);
        cycle(1'b1, 3'd0, 8'h30);
        checks++;
        if (real_sec !== 8'h30 || sec_tick !== 1'b0 || dut_bus !== model_outputs()) begin
            errors++; $display("FAIL write_on_adv: sec %h tick %b want 30 0", real_sec, sec_tick);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 3'd0, 8'h00);
            checks++;
            if (sec_tick !== 1'b0 || real_sec !== 8'h30) begin
                errors++; $display("FAIL adv_dropped %0d: sec %h tick %b want 30 0", i, real_sec, sec_tick);
            end
        end
        cycle(1'b0, 3'd0, 8'h00);
        checks++;
        if (real_sec !== 8'h31 || sec_tick !== 1'b1) begin
            errors++; $display("FAIL tick_after_write: sec %h tick %b want 31 1", real_sec, sec_tick);
        end
    endtask

    task automatic test_reject_on_adv();
        repeat (3) cycle(1'b0, 3'd0, 8'h00);
        cycle(1'b1, 3'd7, 8'h00);
        checks++;
        if (real_sec !== 8'h32 || sec_tick !== 1'b1 || wr_err !== 1'b1) begin
            errors++; $display("FAIL reject_on_adv: sec %h tick %b err %b want 32 1 1", real_sec, sec_tick, wr_err);
        end
    endtask

    task automatic test_random();
        logic       en;
        logic [2:0] a;
        logic [7:0] d;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) == 0);
            a  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else                           d = 8'($urandom);
            cycle(en, a, d);
            checks++;
            if (dut_bus !== model_outputs()) begin
                errors++; $display("FAIL random cyc %0d: got %h want %h", i, dut_bus, model_outputs());
            end
        end
    endtask

    task automatic test_reset_mid();
        set_time(8'h99, 8'h12, 8'h31);
        repeat (3) cycle(1'b0, 3'd0, 8'h00);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_bus !== model_outputs()) begin
            errors++; $display("FAIL reset_async: got %h want %h", dut_bus, model_outputs());
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut_bus !== model_outputs()) begin
            errors++; $display("FAIL reset_mid_carry: got %h want %h", dut_bus, model_outputs());
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 3'd0, 8'h00);
            checks++;
            if (dut_bus !== model_outputs()) begin
                errors++; $display("FAIL after_reset %0d: got %h want %h", i, dut_bus, model_outputs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_full_rollover();
        test_feb();
        test_bad_writes();
        test_write_on_adv();
        test_reject_on_adv();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
